// File: rtl/associate_layer.sv
// rtl/associate_layer.sv - NODES-wide fixed-point perceptron layer, time-multiplexed over ARGN arguments.
// Optional bias weight per node enabled by defining ASSOCIATE_BIAS_EN.
module associate_layer #(
    parameter int ARGN      = 2,
    parameter int NODES     = 2,
    parameter int ARG_WIDTH = 8,
    parameter int WGT_WIDTH = 16,
    parameter int RES_WIDTH = 16,
    parameter int FRAC      = 8,
    parameter int RATE      = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           arg_valid,
    output logic                           arg_ready,
    input  logic [ARGN*ARG_WIDTH-1:0]      arg_data,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [NODES*RES_WIDTH-1:0]     res_data,
    input  logic                           err_valid,
    output logic                           err_ready,
    input  logic [NODES*RES_WIDTH-1:0]     err_data,
    output logic                           fbk_valid,
    input  logic                           fbk_ready,
    output logic [ARGN*RES_WIDTH-1:0]      fbk_data
);

`ifdef ASSOCIATE_BIAS_EN
    localparam int NIDX = ARGN + 1;
`else
    localparam int NIDX = ARGN;
`endif
    localparam int XW  = ((ARG_WIDTH > FRAC) ? ARG_WIDTH : FRAC + 1) + 1;
    localparam int IW  = $clog2(NIDX) + 1;
    localparam int AW  = XW + WGT_WIDTH + $clog2(NIDX + 1);
    localparam int FW  = RES_WIDTH + WGT_WIDTH + $clog2(NODES + 1);
    localparam int PW  = RES_WIDTH + XW;
    localparam int UW  = ((PW > WGT_WIDTH) ? PW : WGT_WIDTH) + 1;
    localparam int SW0 = (AW > FW) ? AW : FW;
    localparam int SW  = (SW0 > UW) ? SW0 : UW;

    typedef enum logic [2:0] {IDLE, FWD, RES, ERR, BWD, FBK} state_t;

    state_t state, state_nx;
    logic                        live;
    logic [IW-1:0]               idx;
    logic                        last_idx;
    logic                        en_q;
    logic [ARG_WIDTH-1:0]        arg_q   [ARGN];
    logic signed [WGT_WIDTH-1:0] weight  [NODES][ARGN];
`ifdef ASSOCIATE_BIAS_EN
    logic signed [WGT_WIDTH-1:0] bias    [NODES];
`endif
    logic signed [AW-1:0]        acc     [NODES];
    logic signed [RES_WIDTH-1:0] err_q   [NODES];
    logic signed [RES_WIDTH-1:0] fbk_buf [ARGN];

    logic signed [XW-1:0]        x_cur;
    logic signed [WGT_WIDTH-1:0] w_cur   [NODES];
    logic signed [AW-1:0]        acc_nx  [NODES];
    logic signed [AW-1:0]        acc_sh;
    logic [RES_WIDTH-1:0]        res_sat [NODES];
    logic signed [FW-1:0]        fsum;
    logic signed [FW-1:0]        fsh;
    logic [RES_WIDTH-1:0]        fbk_sat;
    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        dlt;
    logic [WGT_WIDTH-1:0]        w_upd   [NODES];

    // Clamp a sign-extended value to the signed range of the narrower type.
    function automatic logic [RES_WIDTH-1:0] sat_res(input logic [SW-1:0] v);
        logic [RES_WIDTH-1:0] r;
        if (v[SW-1:RES_WIDTH-1] == {(SW-RES_WIDTH+1){v[SW-1]}})
            r = v[RES_WIDTH-1:0];
        else
            r = {v[SW-1], {(RES_WIDTH-1){~v[SW-1]}}};
        return r;
    endfunction

    function automatic logic [WGT_WIDTH-1:0] sat_wgt(input logic [SW-1:0] v);
        logic [WGT_WIDTH-1:0] r;
        if (v[SW-1:WGT_WIDTH-1] == {(SW-WGT_WIDTH+1){v[SW-1]}})
            r = v[WGT_WIDTH-1:0];
        else
            r = {v[SW-1], {(WGT_WIDTH-1){~v[SW-1]}}};
        return r;
    endfunction

    assign last_idx = (idx == IW'(NIDX - 1));

    // Operand select for the current index; the bias slot sits at index ARGN.
    always_comb begin
`ifdef ASSOCIATE_BIAS_EN
        x_cur = XW'(1) << FRAC;
`else
        x_cur = '0;
`endif
        for (int j = 0; j < ARGN; j++)
            if (idx == IW'(j))
                x_cur = XW'({1'b0, arg_q[j]});
        fsum   = '0;
        acc_sh = '0;
        prod   = '0;
        dlt    = '0;
        for (int n = 0; n < NODES; n++) begin
`ifdef ASSOCIATE_BIAS_EN
            w_cur[n] = bias[n];
`else
            w_cur[n] = '0;
`endif
            for (int j = 0; j < ARGN; j++)
                if (idx == IW'(j))
                    w_cur[n] = weight[n][j];
            acc_nx[n]  = acc[n] + AW'(x_cur) * AW'(w_cur[n]);
            acc_sh     = acc_nx[n] >>> FRAC;
            res_sat[n] = sat_res(SW'(acc_sh));
            fsum       = fsum + FW'(err_q[n]) * FW'(w_cur[n]);
            prod       = PW'(err_q[n]) * PW'(x_cur);
            dlt        = prod >>> (FRAC + RATE);
            w_upd[n]   = sat_wgt(SW'(UW'(w_cur[n]) + UW'(dlt)));
        end
        fsh     = fsum >>> FRAC;
        fbk_sat = sat_res(SW'(fsh));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (arg_valid && arg_ready) state_nx = FWD;
            FWD:  if (last_idx) state_nx = RES;
            RES:  if (res_ready) state_nx = en_q ? ERR : IDLE;
            ERR:  if (err_valid) state_nx = BWD;
            BWD:  if (last_idx) state_nx = FBK;
            FBK:  if (fbk_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // live keeps arg_ready low while reset is held and for the release edge.
    always_comb begin
        arg_ready = (state == IDLE) && live;
        res_valid = (state == RES);
        err_ready = (state == ERR);
        fbk_valid = (state == FBK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live     <= 1'b0;
            idx      <= '0;
            en_q     <= 1'b0;
            res_data <= '0;
            fbk_data <= '0;
            for (int j = 0; j < ARGN; j++) begin
                arg_q[j]   <= '0;
                fbk_buf[j] <= '0;
            end
            for (int n = 0; n < NODES; n++) begin
                acc[n]   <= '0;
                err_q[n] <= '0;
`ifdef ASSOCIATE_BIAS_EN
                bias[n]  <= '0;
`endif
                for (int j = 0; j < ARGN; j++)
                    weight[n][j] <= '0;
            end
        end else begin
            live <= 1'b1;
            case (state)
                IDLE: begin
                    if (arg_valid && arg_ready) begin
                        for (int j = 0; j < ARGN; j++)
                            arg_q[j] <= arg_data[j*ARG_WIDTH +: ARG_WIDTH];
                        en_q <= en;
                        idx  <= '0;
                        for (int n = 0; n < NODES; n++)
                            acc[n] <= '0;
                    end
                end
                FWD: begin
                    for (int n = 0; n < NODES; n++)
                        acc[n] <= acc_nx[n];
                    idx <= idx + IW'(1);
                    if (last_idx) begin
                        idx <= '0;
                        for (int n = 0; n < NODES; n++)
                            res_data[n*RES_WIDTH +: RES_WIDTH] <= res_sat[n];
                    end
                end
                ERR: begin
                    if (err_valid) begin
                        for (int n = 0; n < NODES; n++)
                            err_q[n] <= err_data[n*RES_WIDTH +: RES_WIDTH];
                        idx <= '0;
                    end
                end
                BWD: begin
                    // Feedback reads w_cur before this edge commits the update.
                    for (int j = 0; j < ARGN; j++)
                        if (idx == IW'(j))
                            fbk_buf[j] <= fbk_sat;
                    for (int n = 0; n < NODES; n++) begin
                        for (int j = 0; j < ARGN; j++)
                            if (en_q && idx == IW'(j))
                                weight[n][j] <= w_upd[n];
`ifdef ASSOCIATE_BIAS_EN
                        if (en_q && idx == IW'(ARGN))
                            bias[n] <= w_upd[n];
`endif
                    end
                    idx <= idx + IW'(1);
                    if (last_idx) begin
                        idx <= '0;
                        for (int j = 0; j < ARGN; j++)
                            fbk_data[j*RES_WIDTH +: RES_WIDTH] <=
                                (idx == IW'(j)) ? fbk_sat : fbk_buf[j];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_associate_layer.sv
// tb/tb_associate_layer.sv - directed table and sequence bench for associate_layer.
module tb_associate_layer;

`ifdef ASSOCIATE_BIAS_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        arg_valid = 1'b0;
    logic        arg_ready;
    logic [15:0] arg_data = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        err_valid = 1'b0;
    logic        err_ready;
    logic [31:0] err_data = '0;
    logic        fbk_valid;
    logic        fbk_ready = 1'b0;
    logic [31:0] fbk_data;

    int tests = 0;
    int fails = 0;
    int onehot_bad = 0;

    associate_layer uut (
        .clk(clk), .rst(rst), .en(en),
        .arg_valid(arg_valid), .arg_ready(arg_ready), .arg_data(arg_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err_valid(err_valid), .err_ready(err_ready), .err_data(err_data),
        .fbk_valid(fbk_valid), .fbk_ready(fbk_ready), .fbk_data(fbk_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst && ({3'b0, arg_ready} + {3'b0, res_valid} + {3'b0, err_ready} + {3'b0, fbk_valid} > 4'd1))
            onehot_bad++;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0]  a0, a1;
        logic [15:0] w00, w01, w10, w11;
        logic [15:0] r0, r1;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] wt(input int n, input int j);
        return uut.weight[n][j];
    endfunction

    task automatic set_w(input logic [15:0] w00, w01, w10, w11);
        uut.weight[0][0] = w00;
        uut.weight[0][1] = w01;
        uut.weight[1][0] = w10;
        uut.weight[1][1] = w11;
`ifdef ASSOCIATE_BIAS_EN
        uut.bias[0] = '0;
        uut.bias[1] = '0;
`endif
    endtask

    task automatic send_arg(input logic [7:0] a0, a1, input logic en_in);
        int cnt;
        cnt = 0;
        arg_data  = {a1, a0};
        en        = en_in;
        arg_valid = 1'b1;
        while (!arg_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        @(posedge clk);
        #1;
        arg_valid = 1'b0;
        en = ~en_in;
    endtask

    task automatic wait_res(output logic [31:0] res, output int lat, output logic saw_err);
        lat = 0;
        saw_err = 1'b0;
        res = '0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (err_ready) saw_err = 1'b1;
            if (res_valid) break;
        end
        res = res_data;
    endtask

    task automatic ack_res();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic send_err(input logic [15:0] e0, e1);
        int cnt;
        cnt = 0;
        err_data  = {e1, e0};
        err_valid = 1'b1;
        while (!err_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        @(posedge clk);
        #1;
        err_valid = 1'b0;
    endtask

    task automatic wait_fbk(output logic [31:0] fbk, output int lat);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (fbk_valid) break;
        end
        fbk = fbk_data;
        fbk_ready = 1'b1;
        @(posedge clk);
        #1;
        fbk_ready = 1'b0;
    endtask

    vec_t        vecs [6];
    logic [31:0] res, fbk;
    int          lat;
    logic        saw;

    initial begin
        vecs[0] = '{8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{8'hff, 8'hff, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h01fe, 16'h0000};
        vecs[2] = '{8'hff, 8'hff, 16'h7fff, 16'h7fff, 16'h0000, 16'h0000, 16'h7fff, 16'h0000};
        vecs[3] = '{8'hff, 8'hff, 16'h8000, 16'h8000, 16'h0080, 16'hff80, 16'h8000, 16'h0000};
        vecs[4] = '{8'h10, 8'h20, 16'h0080, 16'hff80, 16'hffff, 16'h0000, 16'hfff8, 16'hffff};
        vecs[5] = '{8'h01, 8'h02, 16'h0001, 16'h0000, 16'h0300, 16'h0100, 16'h0000, 16'h0005};

        repeat (3) @(negedge clk);
        check("rst_arg_ready", {31'b0, arg_ready}, 32'd0);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_err_ready", {31'b0, err_ready}, 32'd0);
        check("rst_fbk_valid", {31'b0, fbk_valid}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_fbk_data", fbk_data, 32'd0);
        check("rst_w00", {16'b0, wt(0, 0)}, 32'd0);
        rst = 1'b1;
        #1;
        check("rel_arg_ready_low", {31'b0, arg_ready}, 32'd0);
        @(negedge clk);
        check("rel_arg_ready_high", {31'b0, arg_ready}, 32'd1);

        // err_valid held high throughout must be ignored outside ERR.
        err_valid = 1'b1;
        err_data  = 32'h0100_0100;
        for (int i = 0; i < 6; i++) begin
            set_w(vecs[i].w00, vecs[i].w01, vecs[i].w10, vecs[i].w11);
            send_arg(vecs[i].a0, vecs[i].a1, 1'b0);
            wait_res(res, lat, saw);
            check($sformatf("v%0d_latency", i), lat, LAT);
            check($sformatf("v%0d_res0", i), {16'b0, res[15:0]}, {16'b0, vecs[i].r0});
            check($sformatf("v%0d_res1", i), {16'b0, res[31:16]}, {16'b0, vecs[i].r1});
            ack_res();
            @(negedge clk);
            check($sformatf("v%0d_err_ready", i), {31'b0, saw | err_ready}, 32'd0);
            check($sformatf("v%0d_arg_ready", i), {31'b0, arg_ready}, 32'd1);
            check($sformatf("v%0d_w00", i), {16'b0, wt(0, 0)}, {16'b0, vecs[i].w00});
            check($sformatf("v%0d_w11", i), {16'b0, wt(1, 1)}, {16'b0, vecs[i].w11});
        end
        err_valid = 1'b0;

        // Result held under backpressure.
        set_w(16'h0100, 16'h0100, 16'h0000, 16'h0000);
        send_arg(8'hff, 8'hff, 1'b0);
        wait_res(res, lat, saw);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_res_valid", {31'b0, res_valid}, 32'd1);
            check("hold_res_data", res_data, 32'h0000_01fe);
        end
        ack_res();

        // Training step; en drops right after the arg handshake.
        @(negedge clk);
        set_w(16'h0100, 16'h0200, 16'h0000, 16'h0000);
        send_arg(8'hff, 8'h00, 1'b1);
        wait_res(res, lat, saw);
        check("trn_res0", {16'b0, res[15:0]}, 32'h0000_00ff);
        ack_res();
        @(negedge clk);
        check("trn_err_ready", {31'b0, err_ready}, 32'd1);
        send_err(16'h0010, 16'h0000);
        wait_fbk(fbk, lat);
        check("trn_fbk_latency", lat, LAT);
        check("trn_fbk", fbk, 32'h0020_0010);
        check("trn_w00", {16'b0, wt(0, 0)}, 32'h0000_0107);
        check("trn_w01", {16'b0, wt(0, 1)}, 32'h0000_0200);
        check("trn_w10", {16'b0, wt(1, 0)}, 32'h0000_0000);
        check("trn_w11", {16'b0, wt(1, 1)}, 32'h0000_0000);
        @(negedge clk);
        check("trn_arg_ready", {31'b0, arg_ready}, 32'd1);
        check("trn_fbk_stable", fbk_data, 32'h0020_0010);

        // Reset during BWD.
        set_w(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        send_arg(8'h40, 8'h40, 1'b1);
        wait_res(res, lat, saw);
        ack_res();
        @(negedge clk);
        send_err(16'h0020, 16'h0020);
        rst = 1'b0;
        #1;
        check("abort_fbk_valid", {31'b0, fbk_valid}, 32'd0);
        check("abort_arg_ready", {31'b0, arg_ready}, 32'd0);
        check("abort_w00", {16'b0, wt(0, 0)}, 32'd0);
        check("abort_w11", {16'b0, wt(1, 1)}, 32'd0);
        @(negedge clk);
        check("abort_fbk_valid_next", {31'b0, fbk_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_arg_ready_after", {31'b0, arg_ready}, 32'd1);

`ifdef ASSOCIATE_BIAS_EN
        for (int g = 0; g < 2; g++) begin
            set_w(16'h0000, 16'h0000, 16'h0000, 16'h0000);
            for (int ep = 0; ep < 25; ep++) begin
                for (int p = 0; p < 4; p++) begin
                    logic [7:0]  a0, a1;
                    logic [15:0] tgt, act;
                    a0  = p[0] ? 8'hff : 8'h00;
                    a1  = p[1] ? 8'hff : 8'h00;
                    tgt = (g == 0) ? ((p == 3) ? 16'd255 : 16'd0) : ((p != 0) ? 16'd255 : 16'd0);
                    send_arg(a0, a1, 1'b1);
                    wait_res(res, lat, saw);
                    ack_res();
                    act = res[15] ? 16'd0 : 16'd255;
                    send_err(tgt - act, 16'h0000);
                    wait_fbk(fbk, lat);
                end
            end
            for (int p = 0; p < 4; p++) begin
                logic [15:0] tgt, act;
                tgt = (g == 0) ? ((p == 3) ? 16'd255 : 16'd0) : ((p != 0) ? 16'd255 : 16'd0);
                send_arg(p[0] ? 8'hff : 8'h00, p[1] ? 8'hff : 8'h00, 1'b0);
                wait_res(res, lat, saw);
                ack_res();
                act = res[15] ? 16'd0 : 16'd255;
                check($sformatf("bias_g%0d_p%0d", g, p), {16'b0, act}, {16'b0, tgt});
            end
        end
`endif

        check("one_hot_handshakes", onehot_bad, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/associate_layer.md
Name: associate_layer

Overview:
- Parametrised successor to the single-node `associate` perceptron: NODES nodes share one argument vector, with valid/ready handshakes on all four streams.
  - Forward: each node computes a fixed-point weighted sum.
  - Backward: per-argument feedback is accumulated across nodes, and weights are updated with a shift learning rate.
- Time-multiplexed over ARGN (one argument index per cycle, all nodes in parallel).
- Sits between layers in the machina network datapath.

Parameters:
- ARGN, 2, number of arguments per vector
- NODES, 2, number of nodes (output channels)
- ARG_WIDTH, 8, unsigned argument width; 0xff represents ~1.0
- WGT_WIDTH, 16, signed weight width; FRAC fractional bits
- RES_WIDTH, 16, signed result, error and feedback width
- FRAC, 8, fractional bits of weights and results
- RATE, 1, learning-rate right shift

Ports:
- clk, input, 1, clock
- rst, input, 1, asynchronous active-low reset
- en, input, 1, training enable; sampled at the arg handshake
- arg_valid, input, 1, argument vector valid
- arg_ready, output, 1, block accepts argument vector
- arg_data, input, ARGN*ARG_WIDTH, argument j at bits [j*ARG_WIDTH +: ARG_WIDTH]
- res_valid, output, 1, result vector valid
- res_ready, input, 1, downstream accepts result
- res_data, output, NODES*RES_WIDTH, signed result per node
- err_valid, input, 1, error vector valid
- err_ready, output, 1, block accepts error vector
- err_data, input, NODES*RES_WIDTH, signed error per node
- fbk_valid, output, 1, feedback vector valid
- fbk_ready, input, 1, upstream accepts feedback
- fbk_data, output, ARGN*RES_WIDTH, signed feedback per argument

Behaviour:
- Reset (async, rst=0):
  - State IDLE.
  - All weights 0.
  - arg_ready=0, res_valid=0, err_ready=0, fbk_valid=0.
  - res_data=0, fbk_data=0.
  - arg_ready rises the first cycle after rst deasserts.
- FSM states: IDLE, FWD, RES, ERR, BWD, FBK.
- IDLE:
  - arg_ready=1.
  - On arg_valid&arg_ready: latch arg_data, latch en into en_q, clear accumulators, go to FWD.
- FWD: ARGN cycles, index j=0..ARGN-1.
  - Each node: acc[n] += $signed({1'b0,arg[j]}) * w[n][j].
  - Accumulator is wide enough to avoid overflow (ARG_WIDTH+WGT_WIDTH+clog2(ARGN+1)+1 bits).
  - After the last index go to RES.
- RES:
  - res_data[n] = acc[n] >>> FRAC, saturated to the signed RES_WIDTH range.
  - res_valid=1 from the first RES cycle, held stable until res_ready.
  - Latency: arg accepted in cycle T gives res_valid in cycle T+ARGN+1.
  - On handshake: go to ERR if en_q, else IDLE.
- ERR:
  - err_ready=1; latch err_data on err_valid.
  - Go to BWD.
- BWD: ARGN cycles, index j.
  - fbk[j] = sat((sum over n of err[n]*w[n][j]) >>> FRAC), computed with the pre-update weights.
  - Then each weight: w[n][j] = sat_WGT(w[n][j] + ((err[n]*arg[j]) >>> (FRAC+RATE))).
  - Arithmetic right shifts floor toward -inf.
  - After the last index go to FBK.
- FBK:
  - fbk_valid=1, held until fbk_ready, then IDLE.
- Stability rules:
  - res_data and fbk_data hold their values until the next RES/FBK load.
  - Only one of the four ready/valid outputs is high in any cycle.
- Error and training rules:
  - err_valid is ignored outside ERR.
  - en changes after the arg handshake have no effect on the current transaction.
  - en_q=0 means weights never change.
- Saturation is symmetric to the type limits, e.g. RES_WIDTH=16 gives 0x7fff / 0x8000.
- Reset asserted mid-operation (any state) aborts the transaction immediately: valids drop and weights clear.
- Weights are reachable hierarchically as uut.weight[n][j] for bench preload.

Optional Feature:
- Macro: ASSOCIATE_BIAS_EN.
- Defined:
  - Each node gains a bias weight bias[n] (reset 0), treated as argument index ARGN with a constant input of 1<<FRAC.
  - FWD and BWD take ARGN+1 cycles; latency becomes T+ARGN+2.
  - Bias is updated like any other weight.
  - Bias is not included in fbk_data.
- Undefined: no bias logic; the node output is 0 for an all-zero argument.

Test Plan (ARGN=2, NODES=2, defaults):
- Reset, then arg {0x00,0x00} -> res_data {0x0000,0x0000}; res_valid exactly 3 cycles after the arg handshake; arg_ready high again after the res handshake.
- Preload w[0]={0x0100,0x0100}, arg {0xff,0xff}, en=0 -> res[0]=0x01fe, res[1]=0; err_ready never asserts; weights unchanged.
- Preload w[0]={0x7fff,0x7fff}, arg {0xff,0xff} -> res[0]=0x7fff (saturated); w[0]={0x8000,0x8000} -> res[0]=0x8000.
- en=1, w[0]={0x0100,0x0200}, w[1]={0,0}, arg {0xff,0x00}, err {0x0010,0x0000} -> fbk {0x0010,0x0020}; w[0][0]=0x0107, w[0][1]=0x0200, w[1] unchanged.
- With ASSOCIATE_BIAS_EN, train node 0 for 25 epochs on AND, then OR (args {00,00},{ff,00},{00,ff},{ff,ff}; act = res<0 ? 0 : 0xff; err = tgt-act) -> zero error on all four patterns with en=0.
- Hold res_ready=0 for 5 cycles -> res_data and res_valid stable; assert rst during BWD -> next cycle fbk_valid=0, all weights 0, arg_ready=1 after release.
